// File: rtl/lsu.sv
// lsu: load/store unit bridging a core request port to a word-wide memory; define LSU_RMW_EN to enable read-modify-write for sub-word stores at nonzero byte offsets
module lsu #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SIZE      = 1024
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef LSU_RMW_EN
    RMW_RD,
`endif
    WRITE,
    RESP
  } state_t;
  localparam logic [31:0] DEPTH = 32'(SIZE);
  state_t state, nxt, st_first;
  logic accept, misalign, out_of_range, sub, req_err, in_rmw;
  logic [31:0] off_addr, ld_shift, ld_ext, st_mask, merged;
  logic [4:0] sh;
  logic [3:0] dir_we;
  logic [1:0] size_q;
  logic uns_q, err_q;
  logic [3:0] mwe_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  assign accept = req_valid_i & req_ready_o;
  assign off_addr = req_addr_i - BASE_ADDR;
  assign misalign = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign out_of_range = req_addr_i < BASE_ADDR || {2'b00, off_addr} >= {DEPTH, 2'b00};
  assign sub = req_size_i != 2'b10 && req_addr_i[1:0] != 2'b00;
  assign dir_we = req_size_i == 2'b10 ? 4'b1111 : req_size_i == 2'b01 ? 4'b0011 : 4'b0001;
`ifdef LSU_RMW_EN
  assign req_err = misalign || out_of_range;
  assign st_first = sub ? RMW_RD : WRITE;
  assign in_rmw = state == RMW_RD;
`else
  assign req_err = misalign || out_of_range || (req_we_i && sub);
  assign st_first = WRITE;
  assign in_rmw = 1'b0;
`endif
  assign sh = {addr_q[1:0], 3'b000};
  assign ld_shift = mem_rdata_i >> sh;
  assign ld_ext = size_q == 2'b00 ? {{24{!uns_q & ld_shift[7]}}, ld_shift[7:0]} :
                  size_q == 2'b01 ? {{16{!uns_q & ld_shift[15]}}, ld_shift[15:0]} : mem_rdata_i;
  assign st_mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign merged = (mem_rdata_i & ~st_mask) | ((wdata_q << sh) & st_mask);
  // state register
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= nxt;
  // next-state: errors skip memory, stores pick direct write or read-modify-write
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = req_err ? RESP : req_we_i ? st_first : LOAD;
      LOAD: nxt = RESP;
`ifdef LSU_RMW_EN
      RMW_RD: nxt = WRITE;
`endif
      WRITE: nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state; memory port idles at zero
  always_comb begin
    req_ready_o = state == IDLE;
    rsp_valid_o = state == RESP;
    rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    rsp_err_o = rsp_valid_o & err_q;
    mem_en_o = state == LOAD || state == WRITE || in_rmw;
    mem_addr_o = mem_en_o ? {addr_q[31:2], 2'b00} : '0;
    mem_we_o = state == WRITE ? mwe_q : '0;
    mem_wdata_o = state == WRITE ? wdata_q : '0;
  end
  // request latch, load data capture and merged-word capture
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) begin
      size_q <= '0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      mwe_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      size_q <= req_size_i;
      uns_q <= req_unsigned_i;
      err_q <= req_err;
      mwe_q <= sub ? 4'b1111 : dir_we;
      addr_q <= req_addr_i;
      wdata_q <= req_wdata_i;
      rdata_q <= '0;
    end else if (state == LOAD) rdata_q <= ld_ext;
    else if (in_rmw) wdata_q <= merged;
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of memory word 0.
REQ-002 SHALL provide parameter SIZE, default 1024, memory depth in 32-bit words.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid_i in 1, req_ready_o out 1: core request handshake.
REQ-006 SHALL have ports req_we_i in 1 (1=store), req_size_i in 2 (00 byte, 01 half, 10 word), req_unsigned_i in 1 (zero-extend loads).
REQ-007 SHALL have ports req_addr_i in 32 (byte address) and req_wdata_i in 32 (store data, right-aligned).
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_rdata_o out 32, rsp_err_o out 1: one-cycle response pulse, no backpressure.
REQ-009 SHALL have memory-port outputs mem_addr_o 32, mem_en_o 1, mem_we_o 4, mem_wdata_o 32, and input mem_rdata_i 32 (combinational read, synchronous write; only we patterns 1111/0011/0001 are honoured by memory).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-011 SHALL assert req_ready_o only in IDLE; request fields are latched on req_valid_i & req_ready_o and ignored otherwise.
REQ-012 SHALL flag error when: size 11; half at offset 1/3; word at offset !=0; (addr-BASE_ADDR)>>2 >= SIZE or addr < BASE_ADDR.
REQ-013 On accepted error request SHALL go IDLE->RESP with rsp_err_o=1, rsp_rdata_o=0, no memory access (response cycle N+1).
REQ-014 Load SHALL go IDLE->LOAD->RESP; LOAD drives mem_en_o=1, mem_we_o=0000, registers extracted data; rsp_valid_o at cycle N+2.
REQ-015 Load extraction: byte k = mem_rdata_i[8k+7:8k], half k = mem_rdata_i[8k+15:8k], sign-extended unless req_unsigned_i=1; word unchanged.
REQ-016 Direct store (word; half/byte at offset 0) SHALL go IDLE->WRITE->RESP with mem_we_o 1111/0011/0001, mem_wdata_o=req_wdata_i; response N+2.
REQ-017 Sub-word store at nonzero offset SHALL go IDLE->RMW_RD->WRITE->RESP: RMW_RD reads and registers word with target byte(s) replaced; WRITE drives mem_we_o=1111 with merged word; response N+3.
REQ-018 mem_addr_o SHALL equal latched address with bits [1:0] cleared whenever mem_en_o=1.
REQ-019 Outside LOAD/RMW_RD/WRITE SHALL drive mem_en_o=0, mem_we_o=0000, mem_addr_o=0, mem_wdata_o=0.
REQ-020 RESP SHALL assert rsp_valid_o exactly one cycle then return to IDLE; stores return rsp_rdata_o=0.
REQ-021 Back-to-back requests SHALL be accepted the cycle after RESP (IDLE); no overlap.

Reset
REQ-022 On rstn_i=0 SHALL immediately enter IDLE and clear all registers; outputs: req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all mem_* outputs 0.
REQ-023 Reset mid-transaction SHALL drop the transaction with no response and no further memory write.

Configuration
REQ-024 Macro LSU_RMW_EN SHALL compile in the RMW_RD path of REQ-017.
REQ-025 Without LSU_RMW_EN, sub-word stores at nonzero offset SHALL be errors per REQ-013; RMW_RD state is absent.

Verification
REQ-026 Word store 0xDEADBEEF to BASE+0x10 -> WRITE cycle mem_addr_o=0x10, mem_we_o=1111; rsp_valid_o at N+2, err 0.
REQ-027 Signed byte load at BASE+0x11 with word 0x0000_8000 -> rsp_rdata_o=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-028 With LSU_RMW_EN, byte store 0xAB to BASE+0x12 over word 0x1122_3344 -> write 0x11AB_3344, mem_we_o=1111, response N+3; without macro -> rsp_err_o=1 at N+1, no mem_en_o.
REQ-029 Half load at offset 1, word store at offset 2, size 11, address BASE+4*SIZE -> each rsp_err_o=1 at N+1, mem_en_o never asserted.
REQ-030 Assert rstn_i=0 during RMW_RD -> no write, no rsp_valid_o; after release req_ready_o=1 and next load completes normally.
